fetch_stage: RTL

Instruction-fetch stage of the pipelined RV64 core. It owns the program counter, drives the byte address into the combinational instruction memory, and registers the returned 32-bit word with its PC into the IF/ID pipeline register. It handles stall, taken-branch redirect (with flush) and end-of-program halt, and keeps a count of instructions issued to decode.

---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined RV64 core. Owns the program
// counter, presents it as a byte address to a combinational instruction
// memory, and captures the returned word together with its PC into the
// IF/ID pipeline register. Handles hazard stalls, taken-branch redirects
// (which flush IF/ID), and halting when fetch runs past the end of memory.
// Keeps a saturating count of instructions handed to decode.
//
// Parameters
//   RESET_PC    PC value loaded on reset.
//   IMEM_BYTES  instruction memory size in bytes (multiple of 4).
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-high reset
//   stall            in   hold PC and IF/ID for this cycle
//   redirect         in   load redirect_target into PC and flush IF/ID
//   redirect_target  in   redirect destination byte address (low 2 bits ignored)
//   instr_addr       out  byte address to instruction memory (= PC register)
//   instruction      in   word read combinationally at instr_addr
//   id_pc            out  PC of the instruction held in IF/ID
//   id_instruction   out  instruction held in IF/ID (NOP when bubble)
//   id_valid         out  IF/ID holds a real instruction
//   halted           out  fetch ran off the end of memory
//   fetch_count      out  saturating count of valid instructions issued
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic [63:0] instr_addr,
  input  logic [31:0] instruction,
  output logic [63:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP        = 32'h00000013;
  localparam logic [0:0]  ST_RUN     = 1'b0;
  localparam logic [0:0]  ST_HALT    = 1'b1;
  // One bit wider than the PC so that pc + 4 never wraps in the range test.
  localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_BYTES);

  // Count up by one, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Force a byte address onto a word boundary.
  function automatic logic [63:0] word_align(input logic [63:0] a);
    return a & ~64'd3;
  endfunction

  logic [0:0]  r_state;
  logic [63:0] r_pc_p0;
  logic [63:0] r_id_pc_p1;
  logic [31:0] r_id_instr_p1;
  logic        r_vld_p1;
  logic [31:0] r_fetch_count;

  logic        w_run;
  logic        w_in_range;
  logic        w_advance;
  logic        w_fetch;
  logic        w_halt_now;
  logic [63:0] w_pc_plus4;
  logic [63:0] w_redirect_pc;

  assign w_run         = (r_state == ST_RUN);
  assign w_in_range    = (({1'b0, r_pc_p0} + 65'd4) <= IMEM_LIMIT);
  assign w_pc_plus4    = r_pc_p0 + 64'd4;
  assign w_redirect_pc = word_align(redirect_target);

  // Redirect beats stall; stall only matters while running.
  assign w_advance  = w_run & ~redirect & ~stall;
  // A word is only captured when it lies entirely inside memory.
  assign w_fetch    = w_advance & w_in_range;
  assign w_halt_now = w_advance & ~w_in_range;

  // ---- p0: program counter and run/halt state ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else if (redirect) begin
      r_state <= ST_RUN;
    end else if (w_halt_now) begin
      r_state <= ST_HALT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_p0 <= RESET_PC;
    end else if (redirect) begin
      r_pc_p0 <= w_redirect_pc;
    end else if (w_fetch) begin
      r_pc_p0 <= w_pc_plus4;
    end
  end

  // ---- p1: IF/ID pipeline register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_pc_p1    <= 64'd0;
      r_id_instr_p1 <= NOP;
      r_vld_p1      <= 1'b0;
    end else if (redirect) begin
      r_id_pc_p1    <= 64'd0;
      r_id_instr_p1 <= NOP;
      r_vld_p1      <= 1'b0;
    end else if (w_fetch) begin
      r_id_pc_p1    <= r_pc_p0;
      r_id_instr_p1 <= instruction;
      r_vld_p1      <= 1'b1;
    end else if (w_halt_now) begin
      // Out-of-range word is dropped; a bubble goes to decode instead.
      r_id_instr_p1 <= NOP;
      r_vld_p1      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
    end else if (w_fetch) begin
      r_fetch_count <= sat_inc32(r_fetch_count);
    end
  end

  assign instr_addr     = r_pc_p0;
  assign id_pc          = r_id_pc_p1;
  assign id_instruction = r_id_instr_p1;
  assign id_valid       = r_vld_p1;
  assign halted         = (r_state == ST_HALT);
  assign fetch_count    = r_fetch_count;

endmodule
